// File: rtl/mem_stage_lsu_pkg.sv
// Shared types, size codes and lane helpers for the MEM-stage load/store unit.
// Imported by the LSU top and its load-extension sub-module.
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        LsuIdle = 2'd0,
        LsuBusy = 2'd1,
        LsuDone = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SizeW = 2'b01;
    localparam logic [1:0] SizeH = 2'b10;
    localparam logic [1:0] SizeB = 2'b11;

    // 2'b00 from decode is treated as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b00) ? SizeW : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SizeH:   return lane[0];
            SizeB:   return 1'b0;
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SizeH:   return lane[1] ? 4'b1100 : 4'b0011;
            SizeB:   return 4'b0001 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the byte enables alone select it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SizeH:   return {2{wdata[15:0]}};
            SizeB:   return {4{wdata[7:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-bus req/ack interface between the LSU (master) and the data memory (slave).
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 32
) ();

    logic                 bus_req;
    logic                 bus_we;
    logic [ADDR_SIZE-1:0] bus_addr;
    logic [3:0]           bus_be;
    logic [XLEN-1:0]      bus_wdata;
    logic                 bus_ack;
    logic [XLEN-1:0]      bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/mem_stage_lsu_ldext.sv
// Load data extraction: selects the addressed lane of the read word and
// sign- or zero-extends byte/halfword loads.
module mem_stage_lsu_ldext
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        lunsigned,
    output logic [31:0] data
);

    logic [15:0] lane_bits;
    logic        ext_b;
    logic        ext_h;

    assign lane_bits = 16'(rdata >> {lane, 3'b000});
    assign ext_b     = ~lunsigned & lane_bits[7];
    assign ext_h     = ~lunsigned & lane_bits[15];

    always_comb begin
        data = rdata;
        case (size)
            SizeB:   data = {{24{ext_b}}, lane_bits[7:0]};
            SizeH:   data = {{16{ext_h}}, lane_bits[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per load/store,
// stalling the pipeline until the access completes.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memreadM,
    input  logic                 memwriteM,
    input  logic [1:0]           swhbM,
    input  logic                 lunsignedM,
    input  logic [ADDR_SIZE-1:0] addrM,
    input  logic [XLEN-1:0]      wdataM,
    output logic                 stallM,
    output logic                 misalignM,
    output logic [XLEN-1:0]      ldataM,
    mem_stage_lsu_if.master      bus
);

    lsu_state_e state_q, state_d;

    logic                 access;
    logic [1:0]           size_in;
    logic                 mis;
    logic                 accept;
    logic                 ack_fire;
    logic [XLEN-1:0]      ext_data;

    logic                 req_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [3:0]           be_q;
    logic [XLEN-1:0]      wdata_q;
    logic [1:0]           lane_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [XLEN-1:0]      ldata_q;

    assign access  = memreadM | memwriteM;
    assign size_in = norm_size(swhbM);
    assign mis     = misaligned(size_in, addrM[1:0]);

    // Control outputs are forced low while reset is held, even with an access pending.
    always_comb begin
        state_d   = state_q;
        stallM    = 1'b0;
        misalignM = 1'b0;
        accept    = 1'b0;
        ack_fire  = 1'b0;
        unique case (state_q)
            LsuIdle: begin
                if (access && reset) begin
                    if (mis) begin
                        misalignM = 1'b1;
                    end else begin
                        stallM  = 1'b1;
                        accept  = 1'b1;
                        state_d = LsuBusy;
                    end
                end
            end
            LsuBusy: begin
                stallM = reset;
                if (bus.bus_ack && reset) begin
                    ack_fire = 1'b1;
                    state_d  = LsuDone;
                end
            end
            LsuDone: begin
                state_d = LsuIdle;
            end
            default: begin
                state_d = LsuIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LsuIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            lane_q  <= 2'b00;
            size_q  <= SizeW;
            uns_q   <= 1'b0;
            ldata_q <= '0;
        end else if (accept) begin
            req_q   <= 1'b1;
            we_q    <= memwriteM;
            addr_q  <= {addrM[ADDR_SIZE-1:2], 2'b00};
            be_q    <= byte_en(size_in, addrM[1:0]);
            wdata_q <= lane_wdata(size_in, wdataM);
            lane_q  <= addrM[1:0];
            size_q  <= size_in;
            uns_q   <= lunsignedM;
            ldata_q <= '0;
        end else if (ack_fire) begin
            req_q <= 1'b0;
            if (!we_q) begin
                ldata_q <= ext_data;
            end
        end else if (misalignM) begin
            ldata_q <= '0;
        end
    end

    mem_stage_lsu_ldext u_ldext (
        .rdata     (bus.bus_rdata),
        .lane      (lane_q),
        .size      (size_q),
        .lunsigned (uns_q),
        .data      (ext_data)
    );

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign ldataM        = ldata_q;

endmodule
